// File: rtl/inverter_nbit_pipe.sv
// Registered WIDTH-bit conditional inverter (pass / invert / negate / alternating-invert)
// with a one-stage valid/ready output register. Optional INVERTER_NEG_SAT_EN saturates -MIN.
module inverter_nbit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_NEGATE = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    mode_t            mode;
    logic             phase;
    logic             accept;
    logic [WIDTH-1:0] y;
    logic             ovf;

    assign mode     = mode_t'(in_mode);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !rst;

    always_comb begin
        y   = in_data;
        ovf = 1'b0;
        case (mode)
            MODE_PASS:   y = in_data;
            MODE_INVERT: y = ~in_data;
            MODE_NEGATE: begin
`ifdef INVERTER_NEG_SAT_EN
                if (in_data == MOST_NEG) begin
                    y   = MOST_POS;
                    ovf = 1'b1;
                end else begin
                    y = ~in_data + WIDTH'(1);
                end
`else
                y = ~in_data + WIDTH'(1);
`endif
            end
            MODE_TOGGLE: y = in_data ^ {WIDTH{phase}};
            default:     y = in_data;
        endcase
    end

    // Drain without accept keeps out_data; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            phase     <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= y;
            out_ovf   <= ovf;
            phase     <= (mode == MODE_TOGGLE) ? ~phase : 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inverter_nbit_pipe.sv
// Self-checking bench for inverter_nbit_pipe: directed literal cases plus randomized
// traffic checked every cycle against a behavioural model (honours INVERTER_NEG_SAT_EN).
module tb_inverter_nbit_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    inverter_nbit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

`ifdef INVERTER_NEG_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Behavioural model: holds what the output register must present.
    bit     m_valid = 0;
    int     m_data  = 0;
    bit     m_ovf   = 0;
    bit     m_phase = 0;

    always @(posedge clk) begin
        int a;
        a = int'(in_data);
        if (rst) begin
            m_valid = 0; m_data = 0; m_ovf = 0; m_phase = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_ovf   = 0;
            case (in_mode)
                2'd0: m_data = a;
                2'd1: m_data = 255 - a;
                2'd2: begin
                    if (SAT && a == 128) begin
                        m_data = 127; m_ovf = 1;
                    end else begin
                        m_data = (256 - a) % 256;
                    end
                end
                default: m_data = m_phase ? 255 - a : a;
            endcase
            m_phase = (in_mode == 2'd3) ? !m_phase : 0;
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("mdl_out_valid", int'(out_valid), int'(m_valid));
        chk("mdl_in_ready", int'(in_ready), int'(!m_valid || out_ready));
        chk("mdl_out_data", int'(out_data), m_data);
        chk("mdl_out_ovf", int'(out_ovf), int'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [1:0] m, input logic [7:0] exp,
                        input bit exp_ovf, input string nm);
        in_valid = 1'b1; in_data = a; in_mode = m;
        step();
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_data"}, int'(out_data), int'(exp));
        chk({nm, "_ovf"}, int'(out_ovf), int'(exp_ovf));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_mode = 2'd1; out_ready = 1'b1;
        #1;
        repeat (3) step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;

        beat(8'h5A, 2'd3, 8'h5A, 0, "first_toggle");

        beat(8'h3C, 2'd0, 8'h3C, 0, "mode_pass");
        beat(8'h3C, 2'd1, 8'hC3, 0, "mode_inv");
        beat(8'h3C, 2'd2, 8'hC4, 0, "mode_neg");

        beat(8'h0F, 2'd3, 8'h0F, 0, "tog0");
        beat(8'h0F, 2'd3, 8'hF0, 0, "tog1");
        beat(8'h0F, 2'd3, 8'h0F, 0, "tog2");
        beat(8'h0F, 2'd3, 8'hF0, 0, "tog3");
        beat(8'h0F, 2'd0, 8'h0F, 0, "tog_pass");
        beat(8'h0F, 2'd3, 8'h0F, 0, "tog_cleared");

        beat(8'h80, 2'd2, SAT ? 8'h7F : 8'h80, SAT, "neg_min");
        beat(8'h00, 2'd2, 8'h00, 0, "neg_zero");
        beat(8'h01, 2'd2, 8'hFF, 0, "neg_one");

        // Backpressure: drain first so the 0x01 beat is accepted.
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        beat(8'h01, 2'd1, 8'hFE, 0, "bp_load");
        in_data = 8'h55; in_mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", int'(out_data), 8'hFE);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_mode = 2'd1;
        out_ready = 1'b1;
        step();
        chk("bp_drain_accept_data", int'(out_data), 8'hAA);
        chk("bp_drain_accept_valid", int'(out_valid), 1);

        // Mid-stream reset with phase=1 and a held beat.
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        beat(8'h33, 2'd3, 8'h33, 0, "mrst_load");
        rst = 1'b1;
        step();
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_out_data", int'(out_data), 0);
        rst = 1'b0; out_ready = 1'b1;
        beat(8'h0F, 2'd3, 8'h0F, 0, "mrst_phase_cleared");

        // Randomized traffic; the model comparator checks every cycle.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = ($urandom_range(3) != 0);
            in_data   = W'($urandom);
            in_data   = ($urandom_range(7) == 0) ? 8'h80 : in_data;
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
